// File: rtl/refemv_mem_target.sv
// Responder end of the refemv memory bus: word RAM plus an MMIO page (LEDs, TX byte FIFO, cycles).
// Define REFEMV_MEM_CYCLE_CTR_EN to build the free-running CYCLES counter; otherwise offset 3 reads 0.
module refemv_mem_target #(
    parameter int    RAM_WORDS  = 1024,
    parameter string INIT_FILE  = "",
    parameter int    FIFO_DEPTH = 8,
    parameter int    IO_SEL_BIT = 22
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  leds
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifoMem [FIFO_DEPTH];

    logic          isIo;
    logic [2:0]    ioOff;
    logic [AW-1:0] ramIdx;
    logic          ramWe;
    logic          ledsWe;
    logic          pushReq;
    logic          statusClr;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          pop;
    logic          pushOk;
    logic [LW-1:0] freeCnt;
    logic [31:0]   ioRdata;
    logic [31:0]   cyclesRd;

    logic [31:0]   rdataQ, rdataD;
    logic [7:0]    ledsQ, ledsD;
    logic [PW-1:0] rdPtrQ, rdPtrD;
    logic [PW-1:0] wrPtrQ, wrPtrD;
    logic [LW-1:0] levelQ, levelD;
    logic          overflowQ, overflowD;

    logic          unusedAddr;

`ifdef REFEMV_MEM_CYCLE_CTR_EN
    logic [31:0] cyclesQ;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyclesQ <= '0;
        end else begin
            cyclesQ <= cyclesQ + 32'd1;
        end
    end

    assign cyclesRd = cyclesQ;
`else
    assign cyclesRd = '0;
`endif

    // Upper address bits only alias; fold them here so every bit has a reader.
    assign unusedAddr = ^mem_addr;

    always_comb begin
        isIo      = mem_addr[IO_SEL_BIT];
        ioOff     = mem_addr[4:2];
        ramIdx    = mem_addr[AW+1:2];
        ramWe     = (|mem_wmask) && !isIo;
        ledsWe    = isIo && (ioOff == 3'd0) && mem_wmask[0];
        pushReq   = isIo && (ioOff == 3'd1) && mem_wmask[0];
        statusClr = isIo && (ioOff == 3'd2) && mem_wmask[0] && mem_wdata[2];

        fifoFull  = (levelQ == FULL_LEVEL);
        fifoEmpty = (levelQ == '0);
        pop       = !fifoEmpty && tx_ready;
        // A full FIFO still takes a push when the head leaves on the same edge.
        pushOk    = pushReq && (!fifoFull || pop);
        freeCnt   = FULL_LEVEL - levelQ;

        ioRdata = '0;
        case (ioOff)
            3'd0:    ioRdata = {24'h0, ledsQ};
            3'd1:    ioRdata = {24'h0, 8'(freeCnt)};
            3'd2:    ioRdata = {16'h0, 8'(levelQ), 5'h0, overflowQ, fifoFull, fifoEmpty};
            3'd3:    ioRdata = cyclesRd;
            default: ioRdata = '0;
        endcase

        rdataD = rdataQ;
        if (mem_rstrb) begin
            rdataD = isIo ? ioRdata : ram[ramIdx];
        end

        ledsD  = ledsWe ? mem_wdata[7:0] : ledsQ;
        rdPtrD = pop ? rdPtrQ + PW'(1) : rdPtrQ;
        wrPtrD = pushOk ? wrPtrQ + PW'(1) : wrPtrQ;
        levelD = levelQ + LW'(pushOk) - LW'(pop);

        overflowD = overflowQ;
        if (statusClr) begin
            overflowD = 1'b0;
        end
        if (pushReq && !pushOk) begin
            overflowD = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdataQ    <= '0;
            ledsQ     <= '0;
            rdPtrQ    <= '0;
            wrPtrQ    <= '0;
            levelQ    <= '0;
            overflowQ <= 1'b0;
        end else begin
            rdataQ    <= rdataD;
            ledsQ     <= ledsD;
            rdPtrQ    <= rdPtrD;
            wrPtrQ    <= wrPtrD;
            levelQ    <= levelD;
            overflowQ <= overflowD;
        end
    end

    // Storage arrays carry no reset so they can map onto RAM primitives.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ramWe && mem_wmask[i]) begin
                ram[ramIdx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
        if (pushOk) begin
            fifoMem[wrPtrQ] <= mem_wdata[7:0];
        end
    end

    assign mem_rdata = rdataQ;
    assign mem_rbusy = 1'b0;
    assign mem_wbusy = fifoFull && !pop;
    assign tx_data   = fifoMem[rdPtrQ];
    assign tx_valid  = !fifoEmpty;
    assign leds      = ledsQ;

endmodule

// File: tb/tb_refemv_mem_target.sv
// Bench for refemv_mem_target: directed bus scenarios plus randomized RAM and FIFO traffic
// checked against a queue/associative-array model of the memory target.
module tb_refemv_mem_target;
    localparam int RAM_WORDS  = 1024;
    localparam int FIFO_DEPTH = 8;
    localparam int IO_SEL_BIT = 22;
    localparam logic [31:0] IO = 32'h0040_0000;

    logic        clk;
    logic        rstn;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  leds;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] ramModel [logic [31:0]];
    logic [7:0]  txQ [$];
    logic [7:0]  gotBytes [$];
    logic [7:0]  ledsModel;
    logic        ovfModel;
    logic [31:0] cycModel;

    refemv_mem_target #(
        .RAM_WORDS (RAM_WORDS),
        .INIT_FILE (""),
        .FIFO_DEPTH(FIFO_DEPTH),
        .IO_SEL_BIT(IO_SEL_BIT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb),
        .mem_rdata(mem_rdata),
        .mem_rbusy(mem_rbusy),
        .mem_wbusy(mem_wbusy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .leds     (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mmioRead(input logic [2:0] off);
        logic [31:0] lvl;
        lvl = 32'(txQ.size());
        case (off)
            3'd0: return {24'h0, ledsModel};
            3'd1: return 32'(FIFO_DEPTH) - lvl;
            3'd2: return {16'h0, lvl[7:0], 5'h0, ovfModel, lvl == 32'(FIFO_DEPTH), lvl == 32'h0};
`ifdef REFEMV_MEM_CYCLE_CTR_EN
            3'd3: return cycModel;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive inputs, predict from pre-edge model state, clock, then compare.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wmask, input logic rstrb, input logic ready);
        logic        isIo;
        logic [2:0]  off;
        logic [31:0] idx;
        logic        expValid;
        logic [31:0] expRdata;
        logic        popNow;
        logic        pushReq;
        logic        accept;
        logic        expBusy;
        logic [31:0] word;

        isIo = addr[IO_SEL_BIT];
        off  = addr[4:2];
        idx  = (addr >> 2) & 32'(RAM_WORDS - 1);
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wmask = wmask;
        mem_rstrb = rstrb;
        tx_ready  = ready;

        expValid = 1'b0;
        expRdata = 32'h0;
        if (rstrb) begin
            if (isIo) begin
                expValid = 1'b1;
                expRdata = mmioRead(off);
            end else if (ramModel.exists(idx)) begin
                expValid = 1'b1;
                expRdata = ramModel[idx];
            end
        end

        popNow  = (txQ.size() != 0) && ready;
        pushReq = isIo && (off == 3'd1) && wmask[0];
        accept  = pushReq && ((txQ.size() < FIFO_DEPTH) || popNow);
        if (popNow) void'(txQ.pop_front());
        if (accept) txQ.push_back(wdata[7:0]);
        if (isIo && off == 3'd2 && wmask[0] && wdata[2]) ovfModel = 1'b0;
        if (pushReq && !accept) ovfModel = 1'b1;
        if (isIo && off == 3'd0 && wmask[0]) ledsModel = wdata[7:0];
        if (!isIo && wmask != 4'h0) begin
            if (ramModel.exists(idx) || wmask == 4'hF) begin
                word = ramModel.exists(idx) ? ramModel[idx] : 32'h0;
                for (int i = 0; i < 4; i++) begin
                    if (wmask[i]) word[8*i +: 8] = wdata[8*i +: 8];
                end
                ramModel[idx] = word;
            end
        end

        @(posedge clk);
        #1;
        cycModel = cycModel + 32'd1;

        if (expValid) checkOutput("rdata", mem_rdata, expRdata);
        checkOutput("tx_valid", {31'h0, tx_valid}, {31'h0, txQ.size() != 0});
        if (txQ.size() != 0) checkOutput("tx_data", {24'h0, tx_data}, {24'h0, txQ[0]});
        checkOutput("leds", {24'h0, leds}, {24'h0, ledsModel});
        expBusy = (txQ.size() == FIFO_DEPTH) && !ready;
        checkOutput("wbusy", {31'h0, mem_wbusy}, {31'h0, expBusy});
        checkOutput("rbusy", {31'h0, mem_rbusy}, 32'h0);
    endtask

    task automatic resetDut();
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
        tx_ready  = 1'b0;
        rstn      = 1'b0;
        #2;
        ledsModel = 8'h0;
        ovfModel  = 1'b0;
        cycModel  = 32'h0;
        txQ.delete();
    endtask

    task automatic idle(input logic ready);
        applyStimulus(32'h0, 32'h0, 4'h0, 1'b0, ready);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] first;
        int          op;

        resetDut();
        @(posedge clk);
        #1;
        checkOutput("reset_rdata", mem_rdata, 32'h0);
        checkOutput("reset_leds", {24'h0, leds}, 32'h0);
        checkOutput("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        checkOutput("reset_wbusy", {31'h0, mem_wbusy}, 32'h0);
        rstn = 1'b1;

        applyStimulus(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        applyStimulus(32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("ram_full_word", mem_rdata, 32'hDEADBEEF);
        applyStimulus(32'h10, 32'h0000AB00, 4'b0010, 1'b0, 1'b0);
        applyStimulus(32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("ram_lane1", mem_rdata, 32'hDEADABEF);
        applyStimulus(32'h10 + 32'(4 * RAM_WORDS), 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("ram_alias", mem_rdata, 32'hDEADABEF);
        applyStimulus(32'h10, 32'h11223344, 4'hF, 1'b1, 1'b0);
        checkOutput("ram_rw_same_cycle", mem_rdata, 32'hDEADABEF);

        for (int w = 0; w < 32; w++) applyStimulus(32'(w * 4), $urandom, 4'hF, 1'b0, 1'b0);
        for (int n = 0; n < 80; n++) begin
            addr = $urandom & 32'hFFBF_F07F;
            op   = $urandom_range(0, 2);
            case (op)
                0:       applyStimulus(addr, $urandom, 4'($urandom), 1'b0, 1'b0);
                1:       applyStimulus(addr, 32'h0, 4'h0, 1'b1, 1'b0);
                default: applyStimulus(addr, $urandom, 4'($urandom), 1'b1, 1'b0);
            endcase
        end

        applyStimulus(IO | 32'h4, 32'h48, 4'h1, 1'b0, 1'b0);
        applyStimulus(IO | 32'h4, 32'h69, 4'h1, 1'b0, 1'b0);
        applyStimulus(IO | 32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("two_push_status", mem_rdata, 32'h0000_0200);
        checkOutput("two_push_head", {24'h0, tx_data}, 32'h48);
        gotBytes.delete();
        for (int i = 0; i < 2; i++) begin
            if (tx_valid) gotBytes.push_back(tx_data);
            idle(1'b1);
        end
        checkOutput("drain_count", 32'(gotBytes.size()), 32'd2);
        if (gotBytes.size() == 2) begin
            checkOutput("drain_byte0", {24'h0, gotBytes[0]}, 32'h48);
            checkOutput("drain_byte1", {24'h0, gotBytes[1]}, 32'h69);
        end
        applyStimulus(IO | 32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("empty_status", mem_rdata, 32'h0000_0001);

        for (int i = 0; i < 9; i++) applyStimulus(IO | 32'h4, 32'(8'h10 + i), 4'h1, 1'b0, 1'b0);
        checkOutput("overflow_wbusy", {31'h0, mem_wbusy}, 32'h1);
        applyStimulus(IO | 32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("overflow_status", mem_rdata, 32'h0000_0806);
        applyStimulus(IO | 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("full_free", mem_rdata, 32'h0);
        gotBytes.delete();
        for (int i = 0; i < 10; i++) begin
            if (tx_valid) gotBytes.push_back(tx_data);
            idle(1'b1);
        end
        checkOutput("overflow_drain_count", 32'(gotBytes.size()), 32'd8);
        for (int i = 0; i < gotBytes.size() && i < 8; i++) begin
            checkOutput("overflow_drain_byte", {24'h0, gotBytes[i]}, 32'(8'h10 + i));
        end
        applyStimulus(IO | 32'h8, 32'h4, 4'h1, 1'b0, 1'b0);
        applyStimulus(IO | 32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("overflow_cleared", mem_rdata, 32'h0000_0001);

        for (int i = 0; i < 8; i++) applyStimulus(IO | 32'h4, 32'(8'h20 + i), 4'h1, 1'b0, 1'b0);
        applyStimulus(IO | 32'h4, 32'hA5, 4'h1, 1'b0, 1'b1);
        applyStimulus(IO | 32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("full_push_pop_status", mem_rdata, 32'h0000_0802);
        for (int i = 0; i < 9; i++) idle(1'b1);

        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 4);
            case (op)
                0:       idle(1'($urandom));
                1:       applyStimulus(IO | 32'h4, $urandom, 4'h1, 1'b0, 1'($urandom_range(0, 3) == 0));
                2:       applyStimulus(IO | 32'h8, 32'h0, 4'h0, 1'b1, 1'($urandom));
                3:       applyStimulus(IO | 32'h4, 32'h0, 4'h0, 1'b1, 1'($urandom));
                default: applyStimulus(IO | 32'h8, 32'h4, 4'h1, 1'b0, 1'($urandom));
            endcase
        end
        for (int i = 0; i < 10; i++) idle(1'b1);

        applyStimulus(IO, 32'h5A, 4'h1, 1'b0, 1'b0);
        checkOutput("leds_write", {24'h0, leds}, 32'h5A);
        applyStimulus(IO, 32'h0, 4'h0, 1'b1, 1'b0);
        checkOutput("leds_read", mem_rdata, 32'h5A);
        applyStimulus(IO | 32'h14, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0);
        checkOutput("unmapped_read", mem_rdata, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(IO | 32'h4, 32'(8'h30 + i), 4'h1, 1'b0, 1'b0);
        idle(1'b1);
        resetDut();
        checkOutput("async_reset_leds", {24'h0, leds}, 32'h0);
        checkOutput("async_reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        checkOutput("async_reset_rdata", mem_rdata, 32'h0);
        rstn = 1'b1;

        applyStimulus(IO | 32'hC, 32'h0, 4'h0, 1'b1, 1'b0);
        first = mem_rdata;
        for (int i = 0; i < 5; i++) applyStimulus(IO | 32'hC, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
        applyStimulus(IO | 32'hC, 32'h0, 4'h0, 1'b1, 1'b0);
`ifdef REFEMV_MEM_CYCLE_CTR_EN
        checkOutput("cycles_delta", mem_rdata - first, 32'd6);
`else
        checkOutput("cycles_disabled", mem_rdata | first, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
